lamp_fpu_sqrt_round_pack: RTL and testbench
===========================================

// Module: lamp_fpu_sqrt_round_pack
// PURPOSE
// Downstream stage of the lampFPU square-root unit. It takes the unrounded {s, e, f} result
// (f in 01.x|GRS form) and applies round-to-nearest-even, exponent carry and overflow/underflow
// saturation. It packs the result into a LAMP float word and queues it in a 2-entry result buffer
// with a valid/ready handshake towards the FPU writeback.
// PARAMETERS
// E_DW      default LAMP_FLOAT_E_DW (8)   exponent width
// F_DW      default LAMP_FLOAT_F_DW (7)   stored fraction width
// PORTS
// clk           in   1          clock
// rst           in   1          synchronous, active-low reset (rst==0 resets on the clk edge)
// valid_i       in   1          result-present pulse from the sqrt stage; no backpressure is possible upstream
// s_res_i       in   1          result sign
// e_res_i       in   E_DW       biased exponent, pre-rounding
// f_res_i       in   F_DW+5     {0,1,frac[F_DW-1:0],G,R,S}
// isToRound_i   in   1          1: apply rounding; 0: special value (zero/inf/NaN), pass through
// isInvalid_i   in   1          op was invalid (sqrt of negative / SNaN)
// busy_o        out  1          buffer full; issue logic must not start a new sqrt
// valid_o       out  1          head of buffer valid
// ready_i       in   1          consumer accepts the head entry when valid_o&ready_i
// result_o      out  1+E_DW+F_DW  packed {s,e,frac}
// lost_o        out  1          sticky: a valid_i arrived while full and was dropped
// fflags_o      out  5          {NV,DZ,OF,UF,NX} accumulated (macro-dependent)
// fflags_clr_i  in   1          clears fflags_o
// BEHAVIOUR
// - Reset: FIFO emptied, valid_o=0, busy_o=0, result_o=0, lost_o=0, fflags_o=0. Reset mid-operation discards all queued entries.
// - Rounding is combinational on the inputs. The entry is written into the FIFO at the valid_i edge.
//   Latency valid_i -> valid_o is 1 cycle when the FIFO is empty.
// - RNE: lsb=f[3], G=f[2], R=f[1], S=f[0]; inc = G&(R|S|lsb).
//   Compute {c,m} = {1,frac}+inc (F_DW+2 bits).
//   If c (mantissa overflow): frac=0, e=e_res_i+1.
// - Overflow: rounded e == 2^E_DW-1 (or e_res_i already all-ones with isToRound_i=1) -> {s, all-ones, 0} (Inf), OF=1, NX=1.
// - Underflow: isToRound_i & e_res_i==0 -> {s,0,0} (flush to zero), UF=1, NX=1.
// - NX = G|R|S on every rounded result.
// - isToRound_i=0: result = {s_res_i, e_res_i, f_res_i[F_DW+2:3]} unchanged; no OF/UF/NX.
// - FIFO: 2 entries, count 0..2, wrap-around of rd/wr pointers.
//   - push = valid_i & (count<2 | pop).
//   - pop = valid_o & ready_i.
//   - Simultaneous push and pop when full: both happen, nothing lost, count stays 2.
//   - Push while full without pop: entry dropped, lost_o set until reset.
//   - Pop when empty is impossible (valid_o=0).
// - busy_o = (count==2); it is registered and reflects the post-edge count.
// - result_o and valid_o come from the head registers; result_o holds stable while valid_o & ~ready_i.
// CONFIGURATION
// LAMP_FPU_SQRT_FFLAGS_EN
// - Defined: fflags_o ORs in the flags of every pushed entry (NV from isInvalid_i; DZ from rsqrt of zero
//   signalled by isInvalid_i=0, isToRound_i=0, result Inf). Dropped entries do not contribute.
// - fflags_clr_i clears the flags. A clear in the same cycle as a push leaves only the new entry's flags.
// - Not defined: no flag registers; fflags_o tied to 5'b0; fflags_clr_i ignored.
// STRUCTURE
// - lampFPU_pkg gets:
//   - typedef lampFPU_fflags_t (5-bit packed struct NV,DZ,OF,UF,NX);
//   - FUNC_rndToNearestEven(f_res) returning {carry, frac, nx};
//   - constants INF_E_F and ZERO_E_F (already used by the sqrt stage).
// - One sub-module, lamp_fpu_res_fifo2: 2-deep FIFO with count, lost flag and busy.
//   The rounding/packing logic stays in this top module.
// TESTING (bfloat16, E_DW=8, F_DW=7)
// - sqrt(4.0): e_res_i=128, f=01_0000000_000, isToRound_i=1 -> result_o=0x4000 one cycle later, fflags_o NX=0.
// - Tie to even: frac=0000001, GRS=100 -> frac 0000010; frac=0000000, GRS=100 -> frac 0000000; both NX=1.
// - Carry: e=127, frac=1111111, GRS=110 -> result_o=0x4000 (e=128, frac 0).
// - Overflow: e=254, frac=1111111, GRS=100 -> result_o=0x7F80, OF=NX=1; isToRound_i=0 with QNaN input passes 0x7FC0 unchanged.
// - Backpressure: ready_i=0, three valid_i pulses -> busy_o=1 after the 2nd; 3rd dropped with lost_o=1.
//   Then ready_i=1 -> the 2 entries drain in order.
// - Full with push and pop in the same cycle -> no loss, order kept.
//   rst=0 mid-queue -> valid_o=0, lost_o=0, fflags_o=0 next cycle.

Source files
------------

// File: rtl/lampFPU_pkg.sv
// rtl/lampFPU_pkg.sv - lampFPU shared widths, flag type, special-value constants and RNE helper
package lampFPU_pkg;

    localparam int LAMP_FLOAT_E_DW = 8;
    localparam int LAMP_FLOAT_F_DW = 7;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } lampFPU_fflags_t;

    localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] INF_E_F  =
        {{LAMP_FLOAT_E_DW{1'b1}}, {LAMP_FLOAT_F_DW{1'b0}}};
    localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] ZERO_E_F = '0;

    // f_res is {0,1,frac,G,R,S}; returns {carry, frac, nx}
    function automatic logic [LAMP_FLOAT_F_DW+1:0] FUNC_rndToNearestEven(
        input logic [LAMP_FLOAT_F_DW+4:0] f_res
    );
        logic                       lsb;
        logic                       g;
        logic                       r;
        logic                       s;
        logic                       inc;
        logic [LAMP_FLOAT_F_DW+1:0] sum;
        lsb = f_res[3];
        g   = f_res[2];
        r   = f_res[1];
        s   = f_res[0];
        inc = g & (r | s | lsb);
        sum = f_res[LAMP_FLOAT_F_DW+4:3] + {{(LAMP_FLOAT_F_DW+1){1'b0}}, inc};
        // a carry out of the hidden bit leaves 10.000..., so the hidden bit drops to 0
        return {sum[LAMP_FLOAT_F_DW+1] & ~sum[LAMP_FLOAT_F_DW],
                sum[LAMP_FLOAT_F_DW-1:0], g | r | s};
    endfunction

endpackage

// File: rtl/lamp_fpu_res_fifo2.sv
// rtl/lamp_fpu_res_fifo2.sv - 2-entry result FIFO with busy and sticky drop flag
module lamp_fpu_res_fifo2 #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pushValid,
    input  logic [DW-1:0] pushData,
    output logic          pushDone,
    input  logic          popReady,
    output logic          popValid,
    output logic [DW-1:0] popData,
    output logic          busy,
    output logic          lost
);

    logic [DW-1:0] mem [2];
    logic          wrPtr;
    logic          rdPtr;
    logic [1:0]    count;
    logic          lostQ;
    logic          push;
    logic          pop;

    assign popValid = (count != 2'd0);
    assign pop      = popValid & popReady;
    // when full, a same-cycle pop frees the slot that wrPtr already points at
    assign push     = pushValid & ((count != 2'd2) | pop);
    assign pushDone = push;
    assign popData  = mem[rdPtr];
    assign busy     = (count == 2'd2);
    assign lost     = lostQ;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            count  <= 2'd0;
            lostQ  <= 1'b0;
        end else begin
            if (push) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (pushValid & ~push) begin
                lostQ <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lamp_fpu_sqrt_round_pack.sv
// rtl/lamp_fpu_sqrt_round_pack.sv - sqrt RNE rounding, saturation and packing into a 2-entry result queue
// Optional accumulated fflags: LAMP_FPU_SQRT_FFLAGS_EN
module lamp_fpu_sqrt_round_pack
    import lampFPU_pkg::*;
#(
    parameter int E_DW = LAMP_FLOAT_E_DW,
    parameter int F_DW = LAMP_FLOAT_F_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic                 s_res_i,
    input  logic [E_DW-1:0]      e_res_i,
    input  logic [F_DW+4:0]      f_res_i,
    input  logic                 isToRound_i,
    input  logic                 isInvalid_i,
    output logic                 busy_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [E_DW+F_DW:0]   result_o,
    output logic                 lost_o,
    output logic [4:0]           fflags_o,
    input  logic                 fflags_clr_i
);

    logic [F_DW+1:0]      rnd;
    logic                 rndCarry;
    logic [F_DW-1:0]      rndFrac;
    logic                 rndNx;
    logic [E_DW-1:0]      eRnd;
    logic [E_DW+F_DW-1:0] resEF;
    lampFPU_fflags_t      newFlags;
    logic                 pushed;

    assign rnd = FUNC_rndToNearestEven(f_res_i);
    assign {rndCarry, rndFrac, rndNx} = rnd;
    assign eRnd = e_res_i + {{(E_DW-1){1'b0}}, rndCarry};

    always_comb begin
        resEF       = {e_res_i, f_res_i[F_DW+2:3]};
        newFlags    = '0;
        newFlags.nv = isInvalid_i;
        if (isToRound_i) begin
            if (e_res_i == '0) begin
                resEF       = ZERO_E_F;
                newFlags.uf = 1'b1;
                newFlags.nx = 1'b1;
            end else if ((&e_res_i) || (&eRnd)) begin
                resEF       = INF_E_F;
                newFlags.of = 1'b1;
                newFlags.nx = 1'b1;
            end else begin
                resEF       = {eRnd, rndFrac};
                newFlags.nx = rndNx;
            end
        end else begin
            // a valid Inf from the special path can only be rsqrt(0)
            newFlags.dz = ~isInvalid_i & (resEF == INF_E_F);
        end
    end

    lamp_fpu_res_fifo2 #(
        .DW (1 + E_DW + F_DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .pushValid (valid_i),
        .pushData  ({s_res_i, resEF}),
        .pushDone  (pushed),
        .popReady  (ready_i),
        .popValid  (valid_o),
        .popData   (result_o),
        .busy      (busy_o),
        .lost      (lost_o)
    );

`ifdef LAMP_FPU_SQRT_FFLAGS_EN
    lampFPU_fflags_t flagsQ;

    always_ff @(posedge clk) begin
        if (!rst) begin
            flagsQ <= '0;
        end else if (fflags_clr_i) begin
            flagsQ <= pushed ? newFlags : '0;
        end else if (pushed) begin
            flagsQ <= flagsQ | newFlags;
        end
    end

    assign fflags_o = flagsQ;
`else
    logic [6:0] unusedFlags;

    assign unusedFlags = {newFlags, pushed, fflags_clr_i};
    assign fflags_o    = 5'b0;
`endif

endmodule

// File: tb/tb_lamp_fpu_sqrt_round_pack.sv
// tb/tb_lamp_fpu_sqrt_round_pack.sv - self-checking bench for lamp_fpu_sqrt_round_pack (bfloat16)
module tb_lamp_fpu_sqrt_round_pack;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [11:0] f;
        logic        tr;
        logic        inv;
        logic [15:0] res;
        logic [4:0]  fl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic        s_res_i = 1'b0;
    logic [7:0]  e_res_i = '0;
    logic [11:0] f_res_i = '0;
    logic        isToRound_i = 1'b0;
    logic        isInvalid_i = 1'b0;
    logic        busy_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [15:0] result_o;
    logic        lost_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i = 1'b0;

    int checks = 0;
    int errors = 0;

    vec_t vecs[12];

    always #5 clk = ~clk;

    lamp_fpu_sqrt_round_pack dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .s_res_i      (s_res_i),
        .e_res_i      (e_res_i),
        .f_res_i      (f_res_i),
        .isToRound_i  (isToRound_i),
        .isInvalid_i  (isInvalid_i),
        .busy_o       (busy_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .lost_o       (lost_o),
        .fflags_o     (fflags_o),
        .fflags_clr_i (fflags_clr_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] expFl(input logic [4:0] fl);
`ifdef LAMP_FPU_SQRT_FFLAGS_EN
        return fl;
`else
        return 5'b0 & fl;
`endif
    endfunction

    // Reference: round the 8-bit significand by its 3 trailing bits with plain integer arithmetic
    task automatic model(input vec_t v, output logic [15:0] res, output logic [4:0] fl);
        int mant;
        int grs;
        int m2;
        int e2;
        logic [6:0] fr;
        mant = int'(v.f[10:3]);
        grs  = int'(v.f[2:0]);
        m2   = mant + (((grs > 4) || (grs == 4 && (mant % 2) == 1)) ? 1 : 0);
        e2   = int'(v.e) + ((m2 >= 256) ? 1 : 0);
        fr   = m2[6:0];
        fl   = {v.inv, 4'b0000};
        if (!v.tr) begin
            res = {v.s, v.e, v.f[9:3]};
            fl[3] = ~v.inv && (v.e == 8'hFF) && (v.f[9:3] == 7'd0);
        end else if (v.e == 8'd0) begin
            res = {v.s, 15'd0};
            fl[1:0] = 2'b11;
        end else if (v.e == 8'hFF || e2 >= 255) begin
            res = {v.s, 8'hFF, 7'd0};
            fl[2] = 1'b1;
            fl[0] = 1'b1;
        end else begin
            res = {v.s, e2[7:0], fr};
            fl[0] = (grs != 0);
        end
    endtask

    task automatic drive(input vec_t v, input logic clr);
        @(negedge clk);
        valid_i      = 1'b1;
        s_res_i      = v.s;
        e_res_i      = v.e;
        f_res_i      = v.f;
        isToRound_i  = v.tr;
        isInvalid_i  = v.inv;
        fflags_clr_i = clr;
        @(posedge clk);
        #1;
        valid_i      = 1'b0;
        fflags_clr_i = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        vec_t        v;
        logic [15:0] mres;
        logic [4:0]  mfl;
        logic [4:0]  acc;
        logic        clr;

        vecs[0]  = '{1'b0, 8'd128, 12'h400, 1'b1, 1'b0, 16'h4000, 5'b00000};
        vecs[1]  = '{1'b0, 8'd128, 12'h40C, 1'b1, 1'b0, 16'h4002, 5'b00001};
        vecs[2]  = '{1'b0, 8'd128, 12'h404, 1'b1, 1'b0, 16'h4000, 5'b00001};
        vecs[3]  = '{1'b0, 8'd127, 12'h7FE, 1'b1, 1'b0, 16'h4000, 5'b00001};
        vecs[4]  = '{1'b0, 8'd254, 12'h7FC, 1'b1, 1'b0, 16'h7F80, 5'b00101};
        vecs[5]  = '{1'b0, 8'd255, 12'h600, 1'b0, 1'b0, 16'h7FC0, 5'b00000};
        vecs[6]  = '{1'b0, 8'd255, 12'h600, 1'b0, 1'b1, 16'h7FC0, 5'b10000};
        vecs[7]  = '{1'b0, 8'd255, 12'h400, 1'b0, 1'b0, 16'h7F80, 5'b01000};
        vecs[8]  = '{1'b1, 8'd0,   12'h5A5, 1'b1, 1'b0, 16'h8000, 5'b00011};
        vecs[9]  = '{1'b0, 8'd100, 12'h551, 1'b1, 1'b0, 16'h322A, 5'b00001};
        vecs[10] = '{1'b1, 8'd255, 12'h400, 1'b1, 1'b0, 16'hFF80, 5'b00101};
        vecs[11] = '{1'b0, 8'd128, 12'h405, 1'b1, 1'b0, 16'h4001, 5'b00001};

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", valid_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_result", result_o, 0);
        check("reset_lost", lost_o, 0);
        check("reset_fflags", fflags_o, 0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i], 1'b1);
            check($sformatf("vec%0d_valid", i), valid_o, 1);
            check($sformatf("vec%0d_result", i), result_o, vecs[i].res);
            check($sformatf("vec%0d_fflags", i), fflags_o, expFl(vecs[i].fl));
        end

        @(negedge clk);
        fflags_clr_i = 1'b1;
        @(posedge clk);
        #1;
        fflags_clr_i = 1'b0;
        check("clr_only", fflags_o, 0);
        acc = 5'b0;
        for (int i = 0; i < 200; i++) begin
            v.s   = 1'($urandom);
            v.e   = ($urandom_range(0, 3) == 0) ? (($urandom % 2 == 0) ? 8'd0 : 8'hFE + 8'($urandom % 2))
                                                : 8'($urandom);
            v.f   = {2'b01, 10'($urandom)};
            v.tr  = ($urandom_range(0, 4) != 0);
            v.inv = ($urandom_range(0, 7) == 0);
            clr   = ($urandom_range(0, 3) == 0);
            model(v, mres, mfl);
            acc = clr ? mfl : (acc | mfl);
            drive(v, clr);
            check($sformatf("rnd%0d_result", i), result_o, mres);
            check($sformatf("rnd%0d_fflags", i), fflags_o, expFl(acc));
        end

        doReset();
        ready_i = 1'b0;
        drive(vecs[0], 1'b0);
        check("bp_busy1", busy_o, 0);
        drive(vecs[1], 1'b0);
        check("bp_busy2", busy_o, 1);
        check("bp_lost2", lost_o, 0);
        drive(vecs[4], 1'b0);
        check("bp_lost3", lost_o, 1);
        check("bp_busy3", busy_o, 1);
        check("bp_head", result_o, 16'h4000);
        check("bp_fflags", fflags_o, expFl(5'b00001));
        @(negedge clk);
        ready_i = 1'b1;
        #1;
        check("drain_a", result_o, 16'h4000);
        @(posedge clk);
        #1;
        check("drain_b", result_o, 16'h4002);
        check("drain_b_busy", busy_o, 0);
        @(posedge clk);
        #1;
        check("drain_empty", valid_o, 0);
        check("drain_lost_sticky", lost_o, 1);

        doReset();
        check("rst2_lost", lost_o, 0);
        ready_i = 1'b0;
        drive(vecs[9], 1'b0);
        drive(vecs[11], 1'b0);
        check("pp_full", busy_o, 1);
        @(negedge clk);
        ready_i      = 1'b1;
        valid_i      = 1'b1;
        s_res_i      = vecs[10].s;
        e_res_i      = vecs[10].e;
        f_res_i      = vecs[10].f;
        isToRound_i  = vecs[10].tr;
        isInvalid_i  = vecs[10].inv;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check("pp_busy", busy_o, 1);
        check("pp_lost", lost_o, 0);
        check("pp_head", result_o, 16'h4001);
        @(posedge clk);
        #1;
        check("pp_next", result_o, 16'hFF80);
        @(posedge clk);
        #1;
        check("pp_empty", valid_o, 0);

        ready_i = 1'b0;
        drive(vecs[4], 1'b0);
        drive(vecs[8], 1'b0);
        drive(vecs[6], 1'b0);
        check("mid_fflags", fflags_o, expFl(5'b00111));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_lost", lost_o, 0);
        check("mid_rst_fflags", fflags_o, 0);
        check("mid_rst_busy", busy_o, 0);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
